ibex_rf_wb_arbiter: RTL and testbench

- Writeback stage directly upstream of the flop-based register file; owns the single RF write port (waddr/wdata/we).
- Merges two result sources: single-cycle execute results, and load data returning out of band from the LSU.
- Tracks outstanding load destinations in an in-order queue and flags RAW/WAW hazards to the ID stage.
- Registers the RF write: a write presented here lands in the RF on the following clock edge.

---
 rtl/ibex_rf_wb_arbiter_if.sv | 54 +++++
 rtl/ibex_rf_wb_arbiter.sv | 141 ++++++++++++++
 tb/tb_ibex_rf_wb_arbiter.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/ibex_rf_wb_arbiter_if.sv
// Writeback-arbiter bundle: execute result, load issue/response, ID read ports and the RF write port.
// Forwarding outputs exist only when IBEX_RF_WB_FWD_EN is defined.
interface ibex_rf_wb_arbiter_if #(
   parameter int unsigned DataWidth  = 32,
   parameter int unsigned LoadQDepth = 2
);
   localparam int unsigned CntW = $clog2(LoadQDepth + 1);

   logic                 ex_valid_i;
   logic [4:0]           ex_waddr_i;
   logic [DataWidth-1:0] ex_wdata_i;
   logic                 ex_ready_o;
   logic                 lsu_req_i;
   logic [4:0]           lsu_req_waddr_i;
   logic                 lsu_req_ready_o;
   logic                 lsu_rvalid_i;
   logic [DataWidth-1:0] lsu_rdata_i;
   logic                 lsu_err_i;
   logic [4:0]           raddr_a_i;
   logic [4:0]           raddr_b_i;
   logic                 hazard_a_o;
   logic                 hazard_b_o;
   logic [CntW-1:0]      pending_loads_o;
   logic [4:0]           rf_waddr_o;
   logic [DataWidth-1:0] rf_wdata_o;
   logic                 rf_we_o;
`ifdef IBEX_RF_WB_FWD_EN
   logic                 fwd_a_o;
   logic                 fwd_b_o;
   logic [DataWidth-1:0] fwd_data_o;
`endif

   modport slave (
      input  ex_valid_i, ex_waddr_i, ex_wdata_i,
      input  lsu_req_i, lsu_req_waddr_i, lsu_rvalid_i, lsu_rdata_i, lsu_err_i,
      input  raddr_a_i, raddr_b_i,
      output ex_ready_o, lsu_req_ready_o, hazard_a_o, hazard_b_o, pending_loads_o,
      output rf_waddr_o, rf_wdata_o, rf_we_o
`ifdef IBEX_RF_WB_FWD_EN
      , output fwd_a_o, fwd_b_o, fwd_data_o
`endif
   );

   modport master (
      output ex_valid_i, ex_waddr_i, ex_wdata_i,
      output lsu_req_i, lsu_req_waddr_i, lsu_rvalid_i, lsu_rdata_i, lsu_err_i,
      output raddr_a_i, raddr_b_i,
      input  ex_ready_o, lsu_req_ready_o, hazard_a_o, hazard_b_o, pending_loads_o,
      input  rf_waddr_o, rf_wdata_o, rf_we_o
`ifdef IBEX_RF_WB_FWD_EN
      , input fwd_a_o, fwd_b_o, fwd_data_o
`endif
   );
endinterface

// File: rtl/ibex_rf_wb_arbiter.sv
// Writeback arbiter owning the RF write port: merges execute results with out-of-band load data,
// tracks outstanding load destinations and flags hazards. Optional IBEX_RF_WB_FWD_EN adds forwarding.
module ibex_rf_wb_arbiter #(
   parameter int unsigned DataWidth  = 32,
   parameter bit          RV32E      = 1'b0,
   parameter int unsigned LoadQDepth = 2
) (
   input logic                 clk_i,
   input logic                 rst_ni,
   ibex_rf_wb_arbiter_if.slave bus
);
   localparam int unsigned CntW = $clog2(LoadQDepth + 1);
   localparam int unsigned PtrW = (LoadQDepth > 1) ? $clog2(LoadQDepth) : 1;

   logic [4:0]            qaddr_q [LoadQDepth];
   logic [LoadQDepth-1:0] qvld_q, qvld_d;
   logic [PtrW-1:0]       head_q, tail_q;
   logic [CntW-1:0]       count_q, count_d;
   logic                  push, pop;
   logic                  waw_hit, qhit_a, qhit_b, waw;
   logic                  inflight_a, inflight_b;

   logic                  rf_we_q, rf_we_d;
   logic [4:0]            rf_waddr_q, rf_waddr_d;
   logic [DataWidth-1:0]  rf_wdata_q, rf_wdata_d;

   function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
      return (p == PtrW'(LoadQDepth - 1)) ? '0 : p + 1'b1;
   endfunction

   // x0 writes, and x16..x31 on RV32E, complete their handshake but never reach the RF.
   function automatic logic wr_keep(input logic [4:0] a);
      return (a != 5'd0) && !(RV32E && a[4]);
   endfunction

   assign bus.lsu_req_ready_o = (count_q < CntW'(LoadQDepth));
   assign push                = bus.lsu_req_i & bus.lsu_req_ready_o;
   assign pop                 = bus.lsu_rvalid_i & (count_q != '0);
   assign bus.pending_loads_o = count_q;

   always_comb begin
      waw_hit = 1'b0;
      qhit_a  = 1'b0;
      qhit_b  = 1'b0;
      for (int i = 0; i < LoadQDepth; i++) begin
         if (qvld_q[i]) begin
            if (qaddr_q[i] == bus.ex_waddr_i) waw_hit = 1'b1;
            if (qaddr_q[i] == bus.raddr_a_i)  qhit_a  = 1'b1;
            if (qaddr_q[i] == bus.raddr_b_i)  qhit_b  = 1'b1;
         end
      end
   end

   assign waw            = (bus.ex_waddr_i != 5'd0) & waw_hit;
   assign bus.ex_ready_o = bus.ex_valid_i & ~bus.lsu_rvalid_i & ~waw;

   always_comb begin
      qvld_d = qvld_q;
      if (pop)  qvld_d[head_q] = 1'b0;
      if (push) qvld_d[tail_q] = 1'b1;
      count_d = count_q;
      case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         qvld_q  <= '0;
      end else begin
         if (pop)  head_q <= ptr_inc(head_q);
         if (push) tail_q <= ptr_inc(tail_q);
         count_q <= count_d;
         qvld_q  <= qvld_d;
      end
   end

   // Address storage is qualified by qvld_q, so it needs no reset.
   always_ff @(posedge clk_i) begin
      if (push) qaddr_q[tail_q] <= bus.lsu_req_waddr_i;
   end

   // Load responses cannot be stalled, so they always win the write port.
   always_comb begin
      rf_we_d    = 1'b0;
      rf_waddr_d = rf_waddr_q;
      rf_wdata_d = rf_wdata_q;
      if (pop) begin
         rf_waddr_d = qaddr_q[head_q];
         rf_wdata_d = bus.lsu_rdata_i;
         rf_we_d    = ~bus.lsu_err_i & wr_keep(qaddr_q[head_q]);
      end else if (bus.ex_ready_o) begin
         rf_waddr_d = bus.ex_waddr_i;
         rf_wdata_d = bus.ex_wdata_i;
         rf_we_d    = wr_keep(bus.ex_waddr_i);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rf_we_q    <= 1'b0;
         rf_waddr_q <= '0;
         rf_wdata_q <= '0;
      end else begin
         rf_we_q    <= rf_we_d;
         rf_waddr_q <= rf_waddr_d;
         rf_wdata_q <= rf_wdata_d;
      end
   end

   assign bus.rf_we_o    = rf_we_q;
   assign bus.rf_waddr_o = rf_waddr_q;
   assign bus.rf_wdata_o = rf_wdata_q;

   assign inflight_a = rf_we_q & (rf_waddr_q == bus.raddr_a_i);
   assign inflight_b = rf_we_q & (rf_waddr_q == bus.raddr_b_i);

`ifdef IBEX_RF_WB_FWD_EN
   assign bus.hazard_a_o = (bus.raddr_a_i != 5'd0) & qhit_a;
   assign bus.hazard_b_o = (bus.raddr_b_i != 5'd0) & qhit_b;
   assign bus.fwd_a_o    = (bus.raddr_a_i != 5'd0) & inflight_a;
   assign bus.fwd_b_o    = (bus.raddr_b_i != 5'd0) & inflight_b;
   assign bus.fwd_data_o = rf_wdata_q;
`else
   // The in-flight term covers the cycle between the write leaving here and landing in the RF.
   assign bus.hazard_a_o = (bus.raddr_a_i != 5'd0) & (qhit_a | inflight_a);
   assign bus.hazard_b_o = (bus.raddr_b_i != 5'd0) & (qhit_b | inflight_b);
`endif

`ifndef SYNTHESIS
   rvalid_while_empty: assert property (@(posedge clk_i) disable iff (!rst_ni)
      !(bus.lsu_rvalid_i && (count_q == '0)))
      else $error("lsu_rvalid_i asserted with no outstanding load");
`endif

endmodule

// File: tb/tb_ibex_rf_wb_arbiter.sv
// Bench for ibex_rf_wb_arbiter: a default and an RV32E instance share stimulus and are checked
// against a queue-based reference model of the writeback rules.
module tb_ibex_rf_wb_arbiter;
   localparam int unsigned DW = 32;
   localparam int unsigned QD = 2;

   logic clk = 1'b0;
   logic rst_ni = 1'b0;
   always #5 clk = ~clk;

   ibex_rf_wb_arbiter_if #(.DataWidth(DW), .LoadQDepth(QD)) b0 ();
   ibex_rf_wb_arbiter_if #(.DataWidth(DW), .LoadQDepth(QD)) b1 ();

   ibex_rf_wb_arbiter #(.DataWidth(DW), .RV32E(1'b0), .LoadQDepth(QD)) u_dut (
      .clk_i(clk), .rst_ni(rst_ni), .bus(b0));
   ibex_rf_wb_arbiter #(.DataWidth(DW), .RV32E(1'b1), .LoadQDepth(QD)) u_dut_e (
      .clk_i(clk), .rst_ni(rst_ni), .bus(b1));

   assign b1.ex_valid_i      = b0.ex_valid_i;
   assign b1.ex_waddr_i      = b0.ex_waddr_i;
   assign b1.ex_wdata_i      = b0.ex_wdata_i;
   assign b1.lsu_req_i       = b0.lsu_req_i;
   assign b1.lsu_req_waddr_i = b0.lsu_req_waddr_i;
   assign b1.lsu_rvalid_i    = b0.lsu_rvalid_i;
   assign b1.lsu_rdata_i     = b0.lsu_rdata_i;
   assign b1.lsu_err_i       = b0.lsu_err_i;
   assign b1.raddr_a_i       = b0.raddr_a_i;
   assign b1.raddr_b_i       = b0.raddr_b_i;

   int checks = 0;
   int errors = 0;

   // Reference model: outstanding load destinations in order, plus the write now on the RF port.
   logic [4:0]  mq[$];
   bit          mwe0, mwe1;
   logic [4:0]  mwaddr;
   logic [31:0] mwdata;
   bit          last_exr;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic bit inq(input logic [4:0] a);
      foreach (mq[i]) if (mq[i] == a) return 1'b1;
      return 1'b0;
   endfunction

   function automatic bit keep(input logic [4:0] a, input bit e);
      return (a != 5'd0) && !(e && a[4]);
   endfunction

   function automatic bit hz(input logic [4:0] r, input bit we);
      if (r == 5'd0) return 1'b0;
`ifdef IBEX_RF_WB_FWD_EN
      return inq(r);
`else
      return inq(r) || (we && mwaddr == r);
`endif
   endfunction

   task automatic model_clear();
      mq.delete();
      mwe0 = 1'b0; mwe1 = 1'b0; mwaddr = '0; mwdata = '0; last_exr = 1'b0;
   endtask

   task automatic check_all();
      bit exr;
      if (!rst_ni) begin
         model_clear();
         chk("rst_we",      b0.rf_we_o, 0);
         chk("rst_waddr",   b0.rf_waddr_o, 0);
         chk("rst_wdata",   b0.rf_wdata_o, 0);
         chk("rst_pending", b0.pending_loads_o, 0);
         chk("rst_we_e",    b1.rf_we_o, 0);
         chk("rst_pend_e",  b1.pending_loads_o, 0);
         return;
      end
      exr = b0.ex_valid_i && !b0.lsu_rvalid_i && !(b0.ex_waddr_i != 0 && inq(b0.ex_waddr_i));
      last_exr = exr;
      chk("ex_ready",    b0.ex_ready_o, exr);
      chk("req_ready",   b0.lsu_req_ready_o, mq.size() < QD);
      chk("pending",     b0.pending_loads_o, mq.size());
      chk("hazard_a",    b0.hazard_a_o, hz(b0.raddr_a_i, mwe0));
      chk("hazard_b",    b0.hazard_b_o, hz(b0.raddr_b_i, mwe0));
      chk("rf_we",       b0.rf_we_o, mwe0);
      if (mwe0) begin
         chk("rf_waddr", b0.rf_waddr_o, mwaddr);
         chk("rf_wdata", b0.rf_wdata_o, mwdata);
      end
`ifdef IBEX_RF_WB_FWD_EN
      chk("fwd_a", b0.fwd_a_o, mwe0 && b0.raddr_a_i != 0 && mwaddr == b0.raddr_a_i);
      if (mwe0) chk("fwd_data", b0.fwd_data_o, mwdata);
`endif
      chk("e_ex_ready",  b1.ex_ready_o, exr);
      chk("e_pending",   b1.pending_loads_o, mq.size());
      chk("e_hazard_a",  b1.hazard_a_o, hz(b1.raddr_a_i, mwe1));
      chk("e_rf_we",     b1.rf_we_o, mwe1);
      if (mwe1) begin
         chk("e_rf_waddr", b1.rf_waddr_o, mwaddr);
         chk("e_rf_wdata", b1.rf_wdata_o, mwdata);
      end
   endtask

   task automatic model_update();
      bit do_push, do_pop;
      logic [4:0] a;
      if (!rst_ni) return;
      do_push = b0.lsu_req_i && (mq.size() < QD);
      do_pop  = b0.lsu_rvalid_i && (mq.size() > 0);
      if (do_pop) begin
         a = mq.pop_front();
         mwaddr = a; mwdata = b0.lsu_rdata_i;
         mwe0 = !b0.lsu_err_i && keep(a, 1'b0);
         mwe1 = !b0.lsu_err_i && keep(a, 1'b1);
      end else if (last_exr) begin
         mwaddr = b0.ex_waddr_i; mwdata = b0.ex_wdata_i;
         mwe0 = keep(b0.ex_waddr_i, 1'b0);
         mwe1 = keep(b0.ex_waddr_i, 1'b1);
      end else begin
         mwe0 = 1'b0; mwe1 = 1'b0;
      end
      if (do_push) mq.push_back(b0.lsu_req_waddr_i);
   endtask

   task automatic step();
      @(negedge clk);
      check_all();
      model_update();
      @(posedge clk);
      #1;
   endtask

   initial begin
      model_clear();
      b0.ex_valid_i = 1'b1; b0.ex_waddr_i = 5'd1; b0.ex_wdata_i = 32'hA5;
      b0.lsu_req_i = 1'b0; b0.lsu_req_waddr_i = '0; b0.lsu_rvalid_i = 1'b0;
      b0.lsu_rdata_i = '0; b0.lsu_err_i = 1'b0; b0.raddr_a_i = '0; b0.raddr_b_i = '0;

      // Reset held with an execute result pending
      repeat (3) step();
      rst_ni = 1'b1;
      step();
      chk("first_we_x1", b0.rf_we_o, 1);
      chk("first_waddr", b0.rf_waddr_o, 1);

      b0.ex_waddr_i = 5'd5; b0.ex_wdata_i = 32'hDEADBEEF;
      step();
      b0.ex_valid_i = 1'b0; b0.raddr_a_i = 5'd5;
      chk("beef_wdata", b0.rf_wdata_o, 32'hDEADBEEF);
      step();
      b0.raddr_a_i = 5'd0;

      // Two loads fill the queue
      b0.lsu_req_i = 1'b1; b0.lsu_req_waddr_i = 5'd3; step();
      b0.lsu_req_waddr_i = 5'd7; step();
      b0.lsu_req_waddr_i = 5'd9; b0.raddr_b_i = 5'd7;
      chk("full_pending", b0.pending_loads_o, 2);
      chk("full_ready",   b0.lsu_req_ready_o, 0);
      step();
      b0.lsu_req_i = 1'b0; b0.raddr_b_i = 5'd0;
      b0.lsu_rvalid_i = 1'b1; b0.lsu_rdata_i = 32'h11; step();
      chk("ld1_waddr", b0.rf_waddr_o, 3);
      chk("ld1_wdata", b0.rf_wdata_o, 32'h11);
      b0.lsu_rdata_i = 32'h22; step();
      chk("ld2_waddr", b0.rf_waddr_o, 7);
      chk("ld2_wdata", b0.rf_wdata_o, 32'h22);
      b0.lsu_rvalid_i = 1'b0; step();

      // Load response and execute result collide
      b0.lsu_req_i = 1'b1; b0.lsu_req_waddr_i = 5'd2; step();
      b0.lsu_req_i = 1'b0;
      b0.lsu_rvalid_i = 1'b1; b0.lsu_rdata_i = 32'h33;
      b0.ex_valid_i = 1'b1; b0.ex_waddr_i = 5'd9; b0.ex_wdata_i = 32'h99; step();
      chk("col_ld_waddr", b0.rf_waddr_o, 2);
      b0.lsu_rvalid_i = 1'b0; step();
      chk("col_ex_waddr", b0.rf_waddr_o, 9);
      b0.ex_valid_i = 1'b0; step();

      // WAW stall behind a pending load to x4
      b0.lsu_req_i = 1'b1; b0.lsu_req_waddr_i = 5'd4; step();
      b0.lsu_req_i = 1'b0;
      b0.ex_valid_i = 1'b1; b0.ex_waddr_i = 5'd4; b0.ex_wdata_i = 32'h44; step(); step();
      b0.lsu_rvalid_i = 1'b1; b0.lsu_rdata_i = 32'h40; step();
      b0.lsu_rvalid_i = 1'b0; step();
      chk("waw_ex_wdata", b0.rf_wdata_o, 32'h44);
      b0.ex_valid_i = 1'b0; step();

      // Dropped writes: x0, load error, x20 on RV32E
      b0.ex_valid_i = 1'b1; b0.ex_waddr_i = 5'd0; b0.ex_wdata_i = 32'h55; step();
      b0.ex_valid_i = 1'b0;
      b0.lsu_req_i = 1'b1; b0.lsu_req_waddr_i = 5'd6; step();
      b0.lsu_req_i = 1'b0; b0.lsu_rvalid_i = 1'b1; b0.lsu_err_i = 1'b1; b0.lsu_rdata_i = 32'h66; step();
      b0.lsu_rvalid_i = 1'b0; b0.lsu_err_i = 1'b0;
      chk("err_we", b0.rf_we_o, 0);
      b0.ex_valid_i = 1'b1; b0.ex_waddr_i = 5'd20; b0.ex_wdata_i = 32'h2020; step();
      b0.ex_valid_i = 1'b0;
      chk("x20_we_rv32i", b0.rf_we_o, 1);
      chk("x20_we_rv32e", b1.rf_we_o, 0);
      step();

      // Reset mid-operation with a load outstanding and a write in flight
      b0.lsu_req_i = 1'b1; b0.lsu_req_waddr_i = 5'd8; step();
      b0.lsu_req_i = 1'b0; b0.ex_valid_i = 1'b1; b0.ex_waddr_i = 5'd10; b0.ex_wdata_i = 32'hAA; step();
      rst_ni = 1'b0; b0.ex_valid_i = 1'b0;
      step(); step();
      rst_ni = 1'b1;
      step(); step();

      // Randomized traffic, holding any stalled execute result
      for (int n = 0; n < 500; n++) begin
         if (!(b0.ex_valid_i && !last_exr)) begin
            b0.ex_valid_i = ($urandom_range(0, 2) != 0);
            b0.ex_waddr_i = 5'($urandom_range(0, 23));
            b0.ex_wdata_i = $urandom;
         end
         b0.lsu_req_i       = ($urandom_range(0, 2) == 0);
         b0.lsu_req_waddr_i = 5'($urandom_range(0, 23));
         b0.lsu_rvalid_i    = (mq.size() > 0) && ($urandom_range(0, 2) == 0);
         b0.lsu_rdata_i     = $urandom;
         b0.lsu_err_i       = ($urandom_range(0, 7) == 0);
         b0.raddr_a_i       = 5'($urandom_range(0, 23));
         b0.raddr_b_i       = 5'($urandom_range(0, 23));
         step();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
